// File: rtl/weight_control_unit_if.sv
// Handshake bundle between the weight control unit, weight memory, weight store and compute control.
// The master modport is the control unit's view; slave is its environment.
interface weight_control_unit_if #(
    parameter int ADDR_W = 16,
    parameter int ROW_W  = 5
);
    logic              instruction_i;
    logic [8:0]        H_DIM_i;
    logic [8:0]        W_DIM_i;
    logic [ADDR_W-1:0] weight_base_addr_i;
    logic              weight_mem_ready_i;
    logic              next_weight_tile_i;
    logic              weight_mem_rd_o;
    logic [ADDR_W-1:0] weight_mem_addr_o;
    logic              weight_buf_wr_o;
    logic              weight_buf_bank_o;
    logic [ROW_W-1:0]  weight_buf_row_o;
    logic              active_bank_o;
    logic              compute_weights_rdy_o;
    logic              compute_weights_buffered_o;
    logic              done_o;

    modport master (
        input  instruction_i, H_DIM_i, W_DIM_i, weight_base_addr_i,
        input  weight_mem_ready_i, next_weight_tile_i,
        output weight_mem_rd_o, weight_mem_addr_o, weight_buf_wr_o,
        output weight_buf_bank_o, weight_buf_row_o, active_bank_o,
        output compute_weights_rdy_o, compute_weights_buffered_o, done_o
    );

    modport slave (
        output instruction_i, H_DIM_i, W_DIM_i, weight_base_addr_i,
        output weight_mem_ready_i, next_weight_tile_i,
        input  weight_mem_rd_o, weight_mem_addr_o, weight_buf_wr_o,
        input  weight_buf_bank_o, weight_buf_row_o, active_bank_o,
        input  compute_weights_rdy_o, compute_weights_buffered_o, done_o
    );
endinterface

// File: rtl/weight_control_unit.sv
// Fetches MUL_SIZE-row weight tiles into a two-bank weight store, tracks bank occupancy
// and hands tiles to the compute control unit in y-inner, x-outer order.
module weight_control_unit #(
    parameter int MUL_SIZE = 32,
    parameter int ADDR_W   = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    weight_control_unit_if.master bus
);
    localparam int               ROW_W    = $clog2(MUL_SIZE);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [8:0]        r_total, r_fetched;
    logic [ADDR_W-1:0] r_addr;
    logic [ROW_W-1:0]  r_row, r_wr_row;
    logic [1:0]        r_full_cnt, w_full_nxt;
    logic              r_fill_bank, r_active_bank;
    logic              r_wr, r_wr_bank, r_rdy, r_buffered, r_done;
    logic              w_rd, w_accept, w_last_row, w_consume, w_fill_done, w_start, w_done;
    logic [4:0]        w_tiles_x, w_tiles_y;
    logic [8:0]        w_total;

    assign w_tiles_y = 5'(bus.H_DIM_i >> ROW_W) + 5'd1;
    assign w_tiles_x = 5'(bus.W_DIM_i >> ROW_W) + 5'd1;
    assign w_total   = 9'({4'b0, w_tiles_x} * {4'b0, w_tiles_y});

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_accept    = 1'b0;
        w_last_row  = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_consume   = bus.next_weight_tile_i && (r_full_cnt != 2'd0);
        w_fill_done = r_wr && (r_wr_row == LAST_ROW);
        w_full_nxt  = r_full_cnt + {1'b0, w_fill_done} - {1'b0, w_consume};
        case (r_state)
            S_IDLE: begin
                if (bus.instruction_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_rd       = 1'b1;
                w_accept   = bus.weight_mem_ready_i;
                w_last_row = bus.weight_mem_ready_i && (r_row == LAST_ROW);
                // The tile in flight is not yet counted, so any nonzero count means the other bank is occupied
                if (w_last_row && ((w_full_nxt != 2'd0) || (r_fetched + 9'd1 == r_total)))
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_consume && (w_full_nxt == 2'd0) && (r_fetched == r_total)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_consume && (r_fetched != r_total)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_total       <= '0;
            r_fetched     <= '0;
            r_addr        <= '0;
            r_row         <= '0;
            r_wr_row      <= '0;
            r_full_cnt    <= '0;
            r_fill_bank   <= 1'b0;
            r_active_bank <= 1'b0;
            r_wr          <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_rdy         <= 1'b0;
            r_buffered    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_full_cnt <= w_full_nxt;
            r_rdy      <= (w_full_nxt != 2'd0);
            r_buffered <= (w_full_nxt == 2'd2);
            r_done     <= w_done;
            if (w_consume)
                r_active_bank <= ~r_active_bank;
            // Fixed one-cycle memory latency: the write mirrors the accepted read one cycle later
            r_wr <= w_accept;
            if (w_accept) begin
                r_wr_row  <= r_row;
                r_wr_bank <= r_fill_bank;
            end
            if (w_start) begin
                r_total     <= w_total;
                r_fetched   <= '0;
                r_addr      <= bus.weight_base_addr_i;
                r_row       <= '0;
                r_fill_bank <= r_active_bank;
            end else if (w_accept) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_row  <= r_row + ROW_W'(1);
                if (w_last_row) begin
                    r_fetched   <= r_fetched + 9'd1;
                    r_fill_bank <= ~r_fill_bank;
                end
            end
        end
    end

    assign bus.weight_mem_rd_o            = w_rd;
    assign bus.weight_mem_addr_o          = r_addr;
    assign bus.weight_buf_wr_o            = r_wr;
    assign bus.weight_buf_bank_o          = r_wr_bank;
    assign bus.weight_buf_row_o           = r_wr_row;
    assign bus.active_bank_o              = r_active_bank;
    assign bus.compute_weights_rdy_o      = r_rdy;
    assign bus.compute_weights_buffered_o = r_buffered;
    assign bus.done_o                     = r_done;
endmodule

// File: tb/tb_weight_control_unit.sv
// Directed bench for weight_control_unit: table of whole-job vectors plus cycle-exact sequences.
module tb_weight_control_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;

    weight_control_unit_if #(.ADDR_W(16), .ROW_W(5)) bus();

    weight_control_unit #(.MUL_SIZE(32), .ADDR_W(16)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [8:0]  h;
        logic [8:0]  w;
        logic [15:0] base;
        bit          bp;
        int          tiles;
        logic [15:0] last;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic pulse_next;
        bus.next_weight_tile_i = 1'b1;
        tick();
        bus.next_weight_tile_i = 1'b0;
    endtask

    task automatic do_reset;
        rst                    = 1'b1;
        bus.instruction_i      = 1'b0;
        bus.H_DIM_i            = '0;
        bus.W_DIM_i            = '0;
        bus.weight_base_addr_i = '0;
        bus.weight_mem_ready_i = 1'b1;
        bus.next_weight_tile_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start(input logic [8:0] h, input logic [8:0] w, input logic [15:0] base);
        bus.H_DIM_i            = h;
        bus.W_DIM_i            = w;
        bus.weight_base_addr_i = base;
        bus.instruction_i      = 1'b1;
        cyc                    = 0;
        tick();
        bus.instruction_i = 1'b0;
    endtask

    task automatic run_job(input vec_t v, input int idx);
        int          reads = 0, writes = 0, addr_err = 0, wr_err = 0, lat_err = 0;
        int          dones = 0, cons = 0, guard = 0, ph = 0;
        logic [15:0] first_addr = '0, last_addr = '0;
        logic        start_bank;
        bit          prev_acc = 1'b0, acc;
        start_bank = bus.active_bank_o;
        start(v.h, v.w, v.base);
        while (guard < 20000) begin
            if (bus.done_o) begin
                dones++;
                break;
            end
            bus.weight_mem_ready_i = v.bp ? (ph % 3 == 0) : 1'b1;
            ph++;
            bus.next_weight_tile_i = bus.compute_weights_rdy_o && (cyc % 5 == 0);
            if (bus.next_weight_tile_i) cons++;
            acc = bus.weight_mem_rd_o && bus.weight_mem_ready_i;
            if (acc) begin
                if (bus.weight_mem_addr_o !== 16'(v.base + 16'(reads))) addr_err++;
                if (reads == 0) first_addr = bus.weight_mem_addr_o;
                last_addr = bus.weight_mem_addr_o;
                reads++;
            end
            if (bus.weight_buf_wr_o) begin
                if (bus.weight_buf_row_o !== 5'(writes % 32) ||
                    bus.weight_buf_bank_o !== (start_bank ^ 1'((writes / 32) % 2)))
                    wr_err++;
                writes++;
            end
            if (bus.weight_buf_wr_o !== prev_acc) lat_err++;
            prev_acc = acc;
            tick();
            guard++;
        end
        bus.next_weight_tile_i = 1'b0;
        bus.weight_mem_ready_i = 1'b1;
        chk($sformatf("v%0d_done_seen", idx), 32'(dones), 32'd1);
        chk($sformatf("v%0d_reads", idx), 32'(reads), 32'(v.tiles * 32));
        chk($sformatf("v%0d_writes", idx), 32'(writes), 32'(v.tiles * 32));
        chk($sformatf("v%0d_first_addr", idx), 32'(first_addr), 32'(v.base));
        chk($sformatf("v%0d_last_addr", idx), 32'(last_addr), 32'(v.last));
        chk($sformatf("v%0d_addr_seq_err", idx), 32'(addr_err), 32'd0);
        chk($sformatf("v%0d_wr_row_bank_err", idx), 32'(wr_err), 32'd0);
        chk($sformatf("v%0d_wr_latency_err", idx), 32'(lat_err), 32'd0);
        chk($sformatf("v%0d_consumes", idx), 32'(cons), 32'(v.tiles));
        chk($sformatf("v%0d_rdy_at_done", idx), 32'(bus.compute_weights_rdy_o), 32'd0);
        tick();
        chk($sformatf("v%0d_done_pulse", idx), 32'(bus.done_o), 32'd0);
        chk($sformatf("v%0d_idle_rd", idx), 32'(bus.weight_mem_rd_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdc;
        tbl[0] = '{9'd31,  9'd31,  16'h0100, 1'b0, 1,   16'h011F};
        tbl[1] = '{9'd63,  9'd31,  16'h1000, 1'b1, 2,   16'h103F};
        tbl[2] = '{9'd31,  9'd63,  16'h2000, 1'b0, 2,   16'h203F};
        tbl[3] = '{9'd63,  9'd63,  16'h0000, 1'b1, 4,   16'h007F};
        tbl[4] = '{9'd100, 9'd40,  16'hFFF0, 1'b0, 8,   16'h00EF};
        tbl[5] = '{9'd511, 9'd0,   16'h4000, 1'b1, 16,  16'h41FF};
        tbl[6] = '{9'd511, 9'd511, 16'h8000, 1'b0, 256, 16'h9FFF};

        do_reset();
        chk("rst_rd", 32'(bus.weight_mem_rd_o), 32'd0);
        chk("rst_addr", 32'(bus.weight_mem_addr_o), 32'd0);
        chk("rst_wr", 32'(bus.weight_buf_wr_o), 32'd0);
        chk("rst_active", 32'(bus.active_bank_o), 32'd0);
        chk("rst_rdy", 32'(bus.compute_weights_rdy_o), 32'd0);
        chk("rst_buffered", 32'(bus.compute_weights_buffered_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);

        // Single tile, cycle exact
        start(9'd31, 9'd31, 16'h0100);
        chk("a_rd_c1", 32'(bus.weight_mem_rd_o), 32'd1);
        chk("a_addr_c1", 32'(bus.weight_mem_addr_o), 32'h100);
        run_to(2);
        chk("a_wr_c2", 32'(bus.weight_buf_wr_o), 32'd1);
        chk("a_row_c2", 32'(bus.weight_buf_row_o), 32'd0);
        chk("a_bank_c2", 32'(bus.weight_buf_bank_o), 32'd0);
        run_to(32);
        chk("a_addr_c32", 32'(bus.weight_mem_addr_o), 32'h11F);
        run_to(33);
        chk("a_rd_c33", 32'(bus.weight_mem_rd_o), 32'd0);
        chk("a_row_c33", 32'(bus.weight_buf_row_o), 32'd31);
        chk("a_rdy_c33", 32'(bus.compute_weights_rdy_o), 32'd0);
        run_to(34);
        chk("a_rdy_c34", 32'(bus.compute_weights_rdy_o), 32'd1);
        chk("a_buf_c34", 32'(bus.compute_weights_buffered_o), 32'd0);
        run_to(35);
        pulse_next();
        chk("a_done", 32'(bus.done_o), 32'd1);
        chk("a_rdy_after", 32'(bus.compute_weights_rdy_o), 32'd0);
        tick();
        chk("a_done_low", 32'(bus.done_o), 32'd0);

        // Two tiles in y: second bank, buffered timing, two consumes
        do_reset();
        start(9'd63, 9'd31, 16'h0100);
        run_to(33);
        chk("b_addr_c33", 32'(bus.weight_mem_addr_o), 32'h120);
        run_to(34);
        chk("b_bank_c34", 32'(bus.weight_buf_bank_o), 32'd1);
        chk("b_row_c34", 32'(bus.weight_buf_row_o), 32'd0);
        run_to(65);
        chk("b_row_c65", 32'(bus.weight_buf_row_o), 32'd31);
        chk("b_buf_c65", 32'(bus.compute_weights_buffered_o), 32'd0);
        chk("b_rd_c65", 32'(bus.weight_mem_rd_o), 32'd0);
        run_to(66);
        chk("b_buf_c66", 32'(bus.compute_weights_buffered_o), 32'd1);
        run_to(70);
        pulse_next();
        chk("b_active_1", 32'(bus.active_bank_o), 32'd1);
        chk("b_buf_after1", 32'(bus.compute_weights_buffered_o), 32'd0);
        chk("b_done_after1", 32'(bus.done_o), 32'd0);
        run_to(72);
        pulse_next();
        chk("b_active_0", 32'(bus.active_bank_o), 32'd0);
        chk("b_done", 32'(bus.done_o), 32'd1);

        // Four tiles: third tile held until the first consume
        do_reset();
        start(9'd63, 9'd63, 16'h0200);
        run_to(65);
        rdc = 0;
        while (cyc < 80) begin
            if (bus.weight_mem_rd_o) rdc++;
            tick();
        end
        chk("c_no_rd_while_full", 32'(rdc), 32'd0);
        pulse_next();
        chk("c_tile2_rd", 32'(bus.weight_mem_rd_o), 32'd1);
        chk("c_tile2_addr", 32'(bus.weight_mem_addr_o), 32'h240);
        run_to(113);
        chk("c_wait_c113", 32'(bus.weight_mem_rd_o), 32'd0);
        run_to(120);
        pulse_next();
        chk("c_tile3_addr", 32'(bus.weight_mem_addr_o), 32'h260);
        run_to(160);
        pulse_next();
        chk("c_no_done_3rd", 32'(bus.done_o), 32'd0);
        chk("c_rdy_3rd", 32'(bus.compute_weights_rdy_o), 32'd1);
        run_to(165);
        pulse_next();
        chk("c_done_4th", 32'(bus.done_o), 32'd1);

        // Consume coincides with the bank1 last-row write
        do_reset();
        start(9'd63, 9'd31, 16'h0000);
        run_to(65);
        chk("d_wr_row31", 32'(bus.weight_buf_row_o), 32'd31);
        pulse_next();
        chk("d_rdy", 32'(bus.compute_weights_rdy_o), 32'd1);
        chk("d_buf", 32'(bus.compute_weights_buffered_o), 32'd0);
        chk("d_active", 32'(bus.active_bank_o), 32'd1);
        tick();
        chk("d_buf_next", 32'(bus.compute_weights_buffered_o), 32'd0);
        run_to(70);
        pulse_next();
        chk("d_done", 32'(bus.done_o), 32'd1);

        // Reset in the middle of a fetch
        do_reset();
        start(9'd31, 9'd31, 16'h0300);
        run_to(11);
        chk("f_addr_row10", 32'(bus.weight_mem_addr_o), 32'h30A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("f_rd", 32'(bus.weight_mem_rd_o), 32'd0);
        chk("f_wr", 32'(bus.weight_buf_wr_o), 32'd0);
        chk("f_addr", 32'(bus.weight_mem_addr_o), 32'd0);
        chk("f_row", 32'(bus.weight_buf_row_o), 32'd0);
        chk("f_rdy", 32'(bus.compute_weights_rdy_o), 32'd0);
        start(9'd31, 9'd31, 16'h0300);
        chk("f_restart_addr", 32'(bus.weight_mem_addr_o), 32'h300);
        tick();
        chk("f_restart_wr", 32'(bus.weight_buf_wr_o), 32'd1);
        chk("f_restart_row", 32'(bus.weight_buf_row_o), 32'd0);
        run_to(40);
        pulse_next();
        tick();

        // Whole-job vectors
        do_reset();
        for (int i = 0; i < 7; i++) run_job(tbl[i], i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_control_unit.md
Name: weight_control_unit

Overview:
Sequences the fetch of MUL_SIZE x MUL_SIZE weight tiles from weight memory into the two-bank (double-buffered) weight store that feeds the MAC array. It provides the compute control unit with its weight handshakes: compute_weights_rdy (active tile loaded) and compute_weights_buffered (next tile also loaded). It frees a bank on each next_weight_tile pulse. Tile order is y-inner, x-outer, matching the compute control unit's tile traversal.

Parameters:
MUL_SIZE, 32, array dimension; rows per tile (one memory word per row)
ADDR_W, 16, weight memory address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
instruction_i  in  1  start pulse; sampled only in IDLE
H_DIM_i  in  9  matrix height minus 1; latched on start
W_DIM_i  in  9  matrix width minus 1; latched on start
weight_base_addr_i  in  ADDR_W  base row address; latched on start
weight_mem_ready_i  in  1  memory accepts the read request this cycle
next_weight_tile_i  in  1  compute unit finished the active tile (1-cycle pulse)
weight_mem_rd_o  out  1  read request
weight_mem_addr_o  out  ADDR_W  read row address
weight_buf_wr_o  out  1  write returning row into the weight store
weight_buf_bank_o  out  1  bank being written
weight_buf_row_o  out  5  row being written (log2 MUL_SIZE)
active_bank_o  out  1  bank the MAC array computes from
compute_weights_rdy_o  out  1  at least one bank full
compute_weights_buffered_o  out  1  both banks full
done_o  out  1  one-cycle pulse: last tile consumed

Behaviour:
- Reset: all outputs 0; state IDLE; both banks empty; all counters 0. Reset mid-fetch drops the outstanding read: no weight_buf_wr_o in the cycle after reset.
- Derived sizes, latched on start:
  - tiles_y = (H_DIM>>5)+1 and tiles_x = (W_DIM>>5)+1, each 5-bit, range 1..16.
  - total = tiles_x*tiles_y, 9-bit, range 1..256.
- Tile k has y index ty and x index tx, with k = tx*tiles_y + ty.
- Tile base address = base + k*MUL_SIZE, truncated to ADDR_W (wrap permitted).
- States:
  - IDLE: instruction_i goes to FETCH.
  - FETCH: issue reads into the fill bank. Exits:
    - after accepted read row MUL_SIZE-1, go to WAIT if the other bank is full or all tiles are fetched;
    - otherwise stay in FETCH for the next tile on the other bank.
  - WAIT: no reads. Return to FETCH when a bank is freed and fetched < total.
  - After the final consume, return to IDLE.
- Read handshake:
  - weight_mem_rd_o is held high in FETCH.
  - A read is accepted when rd & ready are both high; the address and row then increment.
  - If ready is low, address and row hold.
  - First request is on the cycle after start was sampled.
- Write: fixed one-cycle read latency. weight_buf_wr_o, weight_buf_bank_o and weight_buf_row_o are asserted the cycle after acceptance, carrying that read's bank and row.
- A bank becomes full on the write of row MUL_SIZE-1 (full_cnt +1).
- Consume: next_weight_tile_i while full_cnt>0 gives full_cnt -1 and toggles active_bank_o. next_weight_tile_i with full_cnt==0 is ignored.
- Simultaneous fill completion and consume: full_cnt unchanged; active bank still toggles.
- Flags, registered from the next full_cnt:
  - compute_weights_rdy_o = (full_cnt>=1).
  - compute_weights_buffered_o = (full_cnt==2).
- The fill bank is always the bank not active when full_cnt==1, and the active bank when full_cnt==0.
- done_o pulses on the cycle after the consume that makes full_cnt 0 with fetched==total. The block is then in IDLE.
- instruction_i outside IDLE is ignored.

Test Plan:
- H=31, W=31, base=0x100, ready=1, start at cycle 0:
  - reads at cycles 1..32 to addresses 0x100..0x11F;
  - writes at cycles 2..33, bank0, rows 0..31;
  - rdy_o=1 from cycle 34; buffered_o never 1;
  - next_weight_tile_i pulse -> done_o one cycle later, rdy_o=0.
- H=63, W=31:
  - second tile reads 0x120..0x13F into bank1;
  - buffered_o=1 one cycle after the bank1 row-31 write;
  - two consumes -> active_bank_o 0->1->0, then done_o.
- Backpressure: ready toggles 1,0,0,1...
  - address advances only on accepted cycles; rows 0..31 are each written exactly once, in order.
- H=63, W=63:
  - third tile (address base+64) is not requested until the first consume;
  - fourth tile address is base+96;
  - done_o only after the 4th consume.
- Simultaneous: next_weight_tile_i coincides with the bank1 row-31 write while full_cnt=1:
  - rdy_o stays 1, buffered_o stays 0, active_bank_o toggles.
- rst_i asserted mid-fetch (row 10):
  - next cycle all outputs 0, no weight_buf_wr_o;
  - a new start re-reads from the base address.
